// File: rtl/uart_if.sv
// uart_if: groups the UART transmit/receive handshake and serial lines.
interface uart_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_start;
   logic                 tx;
   logic                 tx_busy;
   logic                 tx_done;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_parity_err;
   logic                 rx_frame_err;
   modport master (
      output tx_data, tx_start, rx,
      input  tx, tx_busy, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );
   modport slave (
      input  tx_data, tx_start, rx,
      output tx, tx_busy, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
   );
endinterface

// File: rtl/uart_param_core.sv
// uart_param_core: parameterised UART transmitter and oversampling receiver
// sharing one free-running baud tick; TX and RX otherwise independent.
module uart_param_core #(
   parameter int CLK_FREQ   = 1000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 1,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input logic   clk,
   input logic   rst,
   uart_if.slave u
);
   localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam int OW  = $clog2(OVERSAMPLE);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;

   logic [DW-1:0]        div_q, div_d;
   logic                 tick;
   logic [2:0]           tx_st_q, tx_st_d, tx_bit_q, tx_bit_d;
   logic [OW-1:0]        tx_os_q, tx_os_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d, tx_line_q, tx_line_d, tx_done_q, tx_done_d;
   logic                 tx_end;
   logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
   logic [2:0]           rx_st_q, rx_st_d, rx_bit_q, rx_bit_d;
   logic [OW-1:0]        rx_os_q, rx_os_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic                 rx_pb_q, rx_pb_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_smp;

   always_comb begin
      tick  = div_q == DIV_LAST;
      div_d = tick ? '0 : div_q + 1'b1;
   end

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_os_d   = tx_os_q;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      tx_par_d  = tx_par_q;
      tx_done_d = 1'b0;
      tx_end    = tick && tx_os_q == OS_LAST;
      if (tx_st_q == S_IDLE) begin
         if (u.tx_start) begin
            tx_st_d  = S_START;
            tx_os_d  = '0;
            tx_bit_d = '0;
            tx_sh_d  = u.tx_data;
            tx_par_d = ^u.tx_data ^ (PARITY == 1);
         end
      end else if (tick) begin
         tx_os_d = tx_end ? '0 : tx_os_q + 1'b1;
         if (tx_end) begin
            if (tx_st_q == S_START) begin
               tx_st_d = S_DATA;
            end else if (tx_st_q == S_DATA) begin
               tx_sh_d  = tx_sh_q >> 1;
               tx_bit_d = tx_bit_q == DATA_LAST ? 3'd0 : tx_bit_q + 1'b1;
               tx_st_d  = tx_bit_q != DATA_LAST ? S_DATA : PARITY == 0 ? S_STOP : S_PAR;
            end else if (tx_st_q == S_PAR) begin
               tx_st_d = S_STOP;
            end else begin
               tx_bit_d  = tx_bit_q == STOP_LAST ? 3'd0 : tx_bit_q + 1'b1;
               tx_st_d   = tx_bit_q == STOP_LAST ? S_IDLE : S_STOP;
               tx_done_d = tx_bit_q == STOP_LAST;
            end
         end
      end
      // line level is registered from the next state so tx never glitches
      tx_line_d = tx_st_d == S_START ? 1'b0 : tx_st_d == S_DATA ? tx_sh_d[0] :
                  tx_st_d == S_PAR ? tx_par_d : 1'b1;
   end

   always_comb begin
      {rx_s3_d, rx_s2_d, rx_s1_d} = {rx_s2_q, rx_s1_q, u.rx};
      rx_st_d    = rx_st_q;
      rx_os_d    = rx_os_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_pb_d    = rx_pb_q;
      rx_data_d  = rx_data_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_valid_d = 1'b0;
      rx_smp     = tick && rx_os_q == (rx_st_q == S_START ? OS_MID : OS_LAST);
      if (rx_st_q == S_IDLE) begin
         if (rx_s3_q && !rx_s2_q) begin
            rx_st_d  = S_START;
            rx_os_d  = '0;
            rx_bit_d = '0;
         end
      end else if (rx_st_q == S_WAIT) begin
         rx_st_d = rx_s2_q ? S_IDLE : S_WAIT;
      end else if (tick) begin
         rx_os_d = rx_smp ? '0 : rx_os_q + 1'b1;
         if (rx_smp) begin
            if (rx_st_q == S_START) begin
               rx_st_d = rx_s2_q ? S_IDLE : S_DATA;
            end else if (rx_st_q == S_DATA) begin
               rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
               rx_bit_d = rx_bit_q == DATA_LAST ? 3'd0 : rx_bit_q + 1'b1;
               rx_st_d  = rx_bit_q != DATA_LAST ? S_DATA : PARITY == 0 ? S_STOP : S_PAR;
            end else if (rx_st_q == S_PAR) begin
               rx_pb_d = rx_s2_q;
               rx_st_d = S_STOP;
            end else begin
               rx_data_d  = rx_sh_q;
               rx_perr_d  = PARITY == 0 ? 1'b0 : ^rx_sh_q ^ rx_pb_q ^ (PARITY == 1);
               rx_ferr_d  = !rx_s2_q;
               rx_valid_d = 1'b1;
               rx_st_d    = rx_s2_q ? S_IDLE : S_WAIT;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q      <= '0;
         tx_st_q    <= S_IDLE;
         tx_os_q    <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
         tx_done_q  <= 1'b0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_st_q    <= S_IDLE;
         rx_os_q    <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_pb_q    <= 1'b0;
         rx_data_q  <= '0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         tx_st_q    <= tx_st_d;
         tx_os_q    <= tx_os_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
         tx_done_q  <= tx_done_d;
         rx_s1_q    <= rx_s1_d;
         rx_s2_q    <= rx_s2_d;
         rx_s3_q    <= rx_s3_d;
         rx_st_q    <= rx_st_d;
         rx_os_q    <= rx_os_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_pb_q    <= rx_pb_d;
         rx_data_q  <= rx_data_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign u.tx            = tx_line_q;
   assign u.tx_busy       = tx_st_q != S_IDLE;
   assign u.tx_done       = tx_done_q;
   assign u.rx_data       = rx_data_q;
   assign u.rx_valid      = rx_valid_q;
   assign u.rx_parity_err = rx_perr_q;
   assign u.rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core: scoreboard bench with an 8O1 instance (TB-driven rx)
// and an 8E1 instance whose tx is looped back to its own rx.
module tb_uart_param_core;
   localparam int CF  = 1600000;
   localparam int BR  = 10000;
   localparam int OS  = 16;
   localparam int BIT = 160;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       f;
   } rx_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_if #(.DATA_BITS(8)) if_o();
   uart_if #(.DATA_BITS(8)) if_e();
   assign if_e.rx = if_e.tx;

   uart_param_core #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .OVERSAMPLE(OS))
      dut_o (.clk(clk), .rst(rst), .u(if_o.slave));
   uart_param_core #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .OVERSAMPLE(OS))
      dut_e (.clk(clk), .rst(rst), .u(if_e.slave));

   rx_t         exp_o[$], exp_e[$], eo, ee;
   logic [10:0] exp_tx[$];
   int          n_chk = 0, n_err = 0, done_o = 0, done_e = 0, val_o = 0, cyc = 0;
   bit          tx_mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (if_o.tx_done) done_o++;
      if (if_e.tx_done) done_e++;
      if (if_o.rx_valid) begin
         val_o++;
         if (exp_o.size() == 0) chk("rx_o_unexpected", 32'(exp_o.size()), 32'd1);
         else begin
            eo = exp_o.pop_front();
            chk("rx_o_word", 32'({if_o.rx_data, if_o.rx_parity_err, if_o.rx_frame_err}), 32'(eo));
         end
      end
      if (if_e.rx_valid) begin
         if (exp_e.size() == 0) chk("rx_e_unexpected", 32'(exp_e.size()), 32'd1);
         else begin
            ee = exp_e.pop_front();
            chk("rx_e_word", 32'({if_e.rx_data, if_e.rx_parity_err, if_e.rx_frame_err}), 32'(ee));
         end
      end
   end

   // deserialises dut_o.tx at bit centres measured from the start-bit edge
   initial begin : tx_mon
      logic [10:0] f;
      logic        prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_mon_en && prev && !if_o.tx) begin
            repeat (BIT / 2) @(negedge clk);
            f[0] = if_o.tx;
            for (int k = 1; k < 11; k++) begin
               repeat (BIT) @(negedge clk);
               f[k] = if_o.tx;
            end
            if (exp_tx.size() == 0) chk("tx_frame_unexpected", 32'(exp_tx.size()), 32'd1);
            else chk("tx_frame", 32'(f), 32'(exp_tx.pop_front()));
         end
         prev = if_o.tx;
      end
   end

   task automatic start_tx(input bit ev, input logic [7:0] d);
      if (ev) begin
         if_e.tx_data  = d;
         if_e.tx_start = 1'b1;
      end else begin
         if_o.tx_data  = d;
         if_o.tx_start = 1'b1;
      end
      @(negedge clk);
      if_e.tx_start = 1'b0;
      if_o.tx_start = 1'b0;
   endtask

   task automatic wait_done(input bit ev, input string nm);
      int t;
      t = 0;
      while (!(ev ? if_e.tx_done : if_o.tx_done) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk(nm, 32'(t < 3000), 32'd1);
   endtask

   task automatic send_bits(input logic [10:0] b);
      for (int i = 0; i < 11; i++) begin
         if_o.rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      if_o.rx = 1'b1;
      repeat (200) @(negedge clk);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, c;
      if_o.tx_data = '0; if_o.tx_start = 1'b0; if_o.rx = 1'b1;
      if_e.tx_data = '0; if_e.tx_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_o", 32'(if_o.tx), 32'd1);
      chk("rst_tx_e", 32'(if_e.tx), 32'd1);
      chk("rst_tx_flags", 32'({if_o.tx_busy, if_o.tx_done}), 32'd0);
      chk("rst_rx_out", 32'({if_o.rx_valid, if_o.rx_data, if_o.rx_parity_err, if_o.rx_frame_err}), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 8O1 transmit of A5 with a rejected start mid-frame
      tx_mon_en = 1'b1;
      exp_tx.push_back(11'b11101001010);
      start_tx(1'b0, 8'hA5);
      c0 = cyc;
      chk("busy_after_start", 32'(if_o.tx_busy), 32'd1);
      repeat (500) @(negedge clk);
      chk("busy_mid_frame", 32'(if_o.tx_busy), 32'd1);
      start_tx(1'b0, 8'h00);
      wait_done(1'b0, "done_o_timeout");
      chk("done_latency", 32'((cyc - c0) >= 1740 && (cyc - c0) <= 1775), 32'd1);
      repeat (2000) @(negedge clk);
      chk("done_count_o", 32'(done_o), 32'd1);
      chk("busy_after_done", 32'(if_o.tx_busy), 32'd0);
      chk("tx_q_empty", 32'(exp_tx.size()), 32'd0);

      // 8E1 loopback, second start in the tx_done clock
      exp_e.push_back('{d: 8'h3C, p: 1'b0, f: 1'b0});
      exp_e.push_back('{d: 8'hFF, p: 1'b0, f: 1'b0});
      start_tx(1'b1, 8'h3C);
      wait_done(1'b1, "lb_done1_timeout");
      start_tx(1'b1, 8'hFF);
      wait_done(1'b1, "lb_done2_timeout");
      repeat (300) @(negedge clk);
      chk("lb_rx_all_seen", 32'(exp_e.size()), 32'd0);
      chk("done_count_e", 32'(done_e), 32'd2);

      // odd parity: 01 with parity 1 is wrong, with parity 0 is right
      exp_o.push_back('{d: 8'h01, p: 1'b1, f: 1'b0});
      send_bits(11'b11000000010);
      exp_o.push_back('{d: 8'h01, p: 1'b0, f: 1'b0});
      send_bits(11'b10000000010);
      chk("parity_all_seen", 32'(exp_o.size()), 32'd0);

      // break: one frame, held flags, then recovery on a clean frame
      c = val_o;
      exp_o.push_back('{d: 8'h00, p: 1'b1, f: 1'b1});
      if_o.rx = 1'b0;
      repeat (3000) @(negedge clk);
      if_o.rx = 1'b1;
      repeat (500) @(negedge clk);
      chk("break_one_valid", 32'(val_o - c), 32'd1);
      chk("break_flags_held", 32'({if_o.rx_data, if_o.rx_parity_err, if_o.rx_frame_err}), 32'h003);
      exp_o.push_back('{d: 8'h5A, p: 1'b0, f: 1'b0});
      send_bits(11'b11010110100);
      chk("after_break_seen", 32'(exp_o.size()), 32'd0);

      // glitch rejection, then a valid frame proves RX is idle
      c = val_o;
      if_o.rx = 1'b0;
      repeat (40) @(negedge clk);
      if_o.rx = 1'b1;
      repeat (400) @(negedge clk);
      chk("glitch_no_valid", 32'(val_o - c), 32'd0);
      chk("glitch_data_held", 32'(if_o.rx_data), 32'h5A);
      exp_o.push_back('{d: 8'hC3, p: 1'b0, f: 1'b0});
      send_bits(11'b11110000110);
      chk("after_glitch_seen", 32'(exp_o.size()), 32'd0);

      // reset 500 clk into a frame
      tx_mon_en = 1'b0;
      c = done_o;
      start_tx(1'b0, 8'h33);
      repeat (499) @(negedge clk);
      chk("busy_before_rst", 32'(if_o.tx_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_tx", 32'(if_o.tx), 32'd1);
      chk("rst_async_busy", 32'(if_o.tx_busy), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2000) @(negedge clk);
      chk("no_done_after_abort", 32'(done_o - c), 32'd0);

      // first start after reset is a fresh frame
      tx_mon_en = 1'b1;
      exp_tx.push_back(11'b11000011110);
      start_tx(1'b0, 8'h0F);
      wait_done(1'b0, "post_rst_done_timeout");
      repeat (100) @(negedge clk);
      chk("post_rst_frame_seen", 32'(exp_tx.size()), 32'd0);
      chk("post_rst_done_count", 32'(done_o - c), 32'd1);
      chk("final_rx_o_q", 32'(exp_o.size()), 32'd0);
      chk("final_rx_e_q", 32'(exp_e.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
